// File: rtl/nmr_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : nmr_bus_pkg
//  Description : Shared widths, address map and control-bit indices for the
//                DSP code-write path into the pulse-sequence FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package nmr_bus_pkg;

    localparam int DW         = 16;
    localparam int LOG2_DEPTH = 4;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_CTRL = 3'd1;

    localparam int CTRL_FIFO_CLR = 0;
    localparam int CTRL_FLAG_CLR = 1;

endpackage : nmr_bus_pkg
`default_nettype wire

// File: rtl/code_wr_fifo_if.sv
`default_nettype none
// ============================================================================
//  Interface   : code_wr_fifo_if
//  Description : DSP write bus, sequencer read handshake and status flags of
//                the code-write FIFO. The master drives the strobe, bus and
//                pop request. The slave (the FIFO) returns data and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface code_wr_fifo_if;
    import nmr_bus_pkg::*;

    logic                  code_en;
    logic [2:0]            xa;
    logic [DW-1:0]         xd;
    logic                  rd_en;
    logic [DW-1:0]         rd_data;
    logic                  rd_vld;
    logic                  empty;
    logic                  full;
    logic [LOG2_DEPTH:0]   count;
    logic                  ovf;
    logic                  unf;

    modport master (
        output code_en, xa, xd, rd_en,
        input  rd_data, rd_vld, empty, full, count, ovf, unf
    );

    modport slave (
        input  code_en, xa, xd, rd_en,
        output rd_data, rd_vld, empty, full, count, ovf, unf
    );

endinterface : code_wr_fifo_if
`default_nettype wire

// File: rtl/code_wr_fifo_core.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_core
//  Description : Single-clock FIFO. Holds the memory, the read and write
//                pointers (each with an extra wrap bit), and registered
//                count/empty/full flags. Pops are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk_sys,
    input  wire logic              rst_n,
    input  wire logic              i_clr,
    input  wire logic              i_push,
    input  wire logic              i_pop,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata,
    output logic                   o_rvld,
    output logic                   o_empty,
    output logic                   o_full,
    output logic      [ADDR_W:0]   o_count
);

    localparam int C_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [C_DEPTH];
    logic [ADDR_W:0]   r_wptr, r_rptr;
    logic [ADDR_W:0]   w_wptr_nxt, w_rptr_nxt;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvld, r_empty, r_full;
    logic              w_push_ok, w_pop_ok;

    // A clear suppresses both push and pop. A push on full or a pop on empty is ignored.
    assign w_push_ok = i_push & ~r_full  & ~i_clr;
    assign w_pop_ok  = i_pop  & ~r_empty & ~i_clr;

    // Next pointer values. The flags are derived from these so that they
    // match the pointers after the edge.
    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        if (i_clr) begin
            w_wptr_nxt = '0;
            w_rptr_nxt = '0;
        end else begin
            if (w_push_ok) w_wptr_nxt = r_wptr + 1'b1;
            if (w_pop_ok)  w_rptr_nxt = r_rptr + 1'b1;
        end
    end

    // Storage array. This array is not reset.
    always_ff @(posedge clk_sys) begin
        if (w_push_ok) r_mem[r_wptr[ADDR_W-1:0]] <= i_wdata;
    end

    // Pointers, flags and the registered read port.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_rvld  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_wptr_nxt - w_rptr_nxt;
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_full  <= (w_wptr_nxt[ADDR_W] != w_rptr_nxt[ADDR_W]) &&
                       (w_wptr_nxt[ADDR_W-1:0] == w_rptr_nxt[ADDR_W-1:0]);
            r_rvld  <= w_pop_ok;
            if (w_pop_ok) r_rdata <= r_mem[r_rptr[ADDR_W-1:0]];
        end
    end

    assign o_rdata = r_rdata;
    assign o_rvld  = r_rvld;
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_count = r_count;

endmodule : sync_fifo_core
`default_nettype wire

// File: rtl/code_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : code_wr_fifo
//  Description : Decodes DSP code_en writes into FIFO pushes or control
//                writes (FIFO clear, flag clear). Keeps the sticky overflow
//                and underflow flags and serves the sequencer read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module code_wr_fifo
    import nmr_bus_pkg::*;
(
    input  wire logic     clk_sys,
    input  wire logic     rst_n,
    code_wr_fifo_if.slave bus
);

    logic w_push_req, w_ctrl_wr, w_fifo_clr, w_flag_clr;
    logic w_ovf_set, w_unf_set;
    logic r_ovf, r_unf;
    logic w_empty, w_full;

    // The bus is trusted to be stable while code_en is high, so it is decoded directly.
    assign w_push_req = bus.code_en && (bus.xa == ADDR_DATA);
    assign w_ctrl_wr  = bus.code_en && (bus.xa == ADDR_CTRL);
    assign w_fifo_clr = w_ctrl_wr & bus.xd[CTRL_FIFO_CLR];
    assign w_flag_clr = w_ctrl_wr & bus.xd[CTRL_FLAG_CLR];

    // A push on full overflows even if a pop happens in the same cycle.
    // A clear takes priority over a pop on empty.
    assign w_ovf_set = w_push_req & w_full;
    assign w_unf_set = bus.rd_en & w_empty & ~w_fifo_clr;

    sync_fifo_core #(
        .DATA_W (DW),
        .ADDR_W (LOG2_DEPTH)
    ) u_core (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_clr   (w_fifo_clr),
        .i_push  (w_push_req),
        .i_pop   (bus.rd_en),
        .i_wdata (bus.xd),
        .o_rdata (bus.rd_data),
        .o_rvld  (bus.rd_vld),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (bus.count)
    );

    // Sticky error flags. A flag clear wins over a set in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (w_flag_clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) r_ovf <= 1'b1;
            if (w_unf_set) r_unf <= 1'b1;
        end
    end

    assign bus.empty = w_empty;
    assign bus.full  = w_full;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;

endmodule : code_wr_fifo
`default_nettype wire

// File: tb/tb_code_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_wr_fifo
//  Description : Scoreboard testbench for code_wr_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_wr_fifo;
    import nmr_bus_pkg::*;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    code_wr_fifo_if u_if ();

    code_wr_fifo u_dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (u_if.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [DW-1:0] m_fifo [$];
    logic [DW-1:0] exp_q  [$];
    logic [DW-1:0] m_rd_data = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    int            max_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, update the model, and check all outputs #1 after the edge.
    task automatic step(input logic ce, input logic [2:0] a, input logic [DW-1:0] d, input logic re);
        logic clr, fclr, push, exp_vld;
        int   sz;
        u_if.code_en = ce;
        u_if.xa      = a;
        u_if.xd      = d;
        u_if.rd_en   = re;
        clr     = ce && (a == 3'd1) && d[0];
        fclr    = ce && (a == 3'd1) && d[1];
        push    = ce && (a == 3'd0);
        exp_vld = 1'b0;
        sz      = m_fifo.size();
        if (!rst_n) begin
            m_fifo.delete();
            m_rd_data = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (clr) begin
                m_fifo.delete();
            end else begin
                if (re && sz > 0) begin
                    exp_q.push_back(m_fifo.pop_front());
                    exp_vld = 1'b1;
                end
                if (push && sz < 16) m_fifo.push_back(d);
            end
            if (fclr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (push && sz == 16)     m_ovf = 1'b1;
                if (re && sz == 0 && !clr) m_unf = 1'b1;
            end
        end
        @(posedge clk_sys);
        #1;
        u_if.code_en = 1'b0;
        u_if.rd_en   = 1'b0;
        chk("rd_vld", u_if.rd_vld, exp_vld);
        if (u_if.rd_vld && exp_q.size() > 0) begin
            m_rd_data = exp_q.pop_front();
        end
        chk("rd_data", u_if.rd_data, m_rd_data);
        chk("count", u_if.count, m_fifo.size());
        chk("empty", u_if.empty, m_fifo.size() == 0);
        chk("full",  u_if.full,  m_fifo.size() == 16);
        chk("ovf",   u_if.ovf,   m_ovf);
        chk("unf",   u_if.unf,   m_unf);
        if (int'(u_if.count) > max_cnt) max_cnt = int'(u_if.count);
    endtask

    task automatic push_w(input logic [DW-1:0] d); step(1'b1, 3'd0, d, 1'b0); endtask
    task automatic pop_w();                        step(1'b0, 3'd0, '0, 1'b1); endtask

    initial begin
        u_if.code_en = 1'b0;
        u_if.xa      = '0;
        u_if.xd      = '0;
        u_if.rd_en   = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_rd_data", u_if.rd_data, 0);
        chk("rst_rd_vld",  u_if.rd_vld, 0);
        chk("rst_empty",   u_if.empty, 1);
        chk("rst_full",    u_if.full, 0);
        chk("rst_count",   u_if.count, 0);
        chk("rst_ovf",     u_if.ovf, 0);
        chk("rst_unf",     u_if.unf, 0);
        rst_n = 1'b1;

        // 1: two pushes and two pops
        push_w(16'h1234);
        push_w(16'hABCD);
        pop_w();
        pop_w();
        step(1'b0, 3'd0, '0, 1'b0);

        // 2: fill, overflow, drain
        for (int i = 0; i < 16; i++) push_w(i[15:0]);
        push_w(16'hFFFF);
        for (int i = 0; i < 16; i++) pop_w();

        // 3: interleaved push/pop across the pointer wrap
        max_cnt = 0;
        push_w(16'd0);
        for (int i = 1; i < 40; i++) step(1'b1, 3'd0, 16'(i * 3), 1'b1);
        pop_w();
        chk("wrap_maxcnt_le2", max_cnt <= 2, 1);

        // 4: underflow, then flag clear
        pop_w();
        step(1'b1, 3'd0, 16'h0BEE, 1'b1);   // push at empty with pop: no read-through
        pop_w();
        step(1'b1, 3'd1, 16'h0002, 1'b0);

        // 5: clear with simultaneous rd_en
        for (int i = 0; i < 5; i++) push_w(16'h0100 + 16'(i));
        step(1'b1, 3'd1, 16'h0001, 1'b1);
        // a flag clear together with an underflow: the clear wins
        step(1'b1, 3'd1, 16'h0002, 1'b1);

        // 6: unmapped address, then reset during a drain
        push_w(16'h00AA);
        push_w(16'h00BB);
        push_w(16'h00CC);
        step(1'b1, 3'd5, 16'h5555, 1'b0);
        pop_w();
        rst_n = 1'b0;
        pop_w();
        rst_n = 1'b1;
        push_w(16'h0777);
        pop_w();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_code_wr_fifo
`default_nettype wire
